serdes_epcs3_link_ctrl: RTL and testbench
=========================================

Name: serdes_epcs3_link_ctrl

Overview:
Bring-up and supervision controller for EPCS lane 3 of the SERDES_IF hard block.
- Sequences the lane's power-down and reset.
- Waits for lane ready and TX clock stable, then enables transmit.
- Monitors the link and retries on loss or timeout.
- Sits in the fabric next to the SERDES_IF wrapper on the APB clock. Its outputs drive the wrapper's EPCS_3_* inputs directly.

Parameters:
RESET_CYCLES, 16, cycles EPCS_3_RESET_N held low per attempt (≥2)
READY_TIMEOUT, 65535, max cycles in WAIT_RDY before retry (16-bit counter)
SETTLE_CYCLES, 32, cycles ready/stable must hold before link declared up
IDLE_LOSS_CYCLES, 1024, consecutive RX_IDLE cycles in UP that count as link loss
MAX_RETRIES, 3, failed attempts before FAIL (1..15)

Ports:
APB_S_PCLK  in  1  single clock for all logic
APB_S_PRESET_N  in  1  asynchronous active-low reset; release synchronized externally
link_en  in  1  request lane up; 0 forces lane down
EPCS_3_READY  in  1  lane ready from SERDES (async, synchronized here)
EPCS_3_TX_CLK_STABLE  in  1  TX clock stable (async, synchronized here)
EPCS_3_RX_IDLE  in  1  RX electrical idle (async, synchronized here)
EPCS_3_PWRDN  out  1  lane power-down to SERDES
EPCS_3_RESET_N  out  1  lane reset to SERDES, active low
EPCS_3_TX_VAL  out  1  TX data valid to SERDES
link_up  out  1  lane operational
link_fail  out  1  retries exhausted
state  out  3  current FSM state encoding

Behaviour:
- Reset values (async, while APB_S_PRESET_N=0): PWRDN=1, RESET_N=0, TX_VAL=0, link_up=0, link_fail=0, state=0. Retry count, timers and synchronizers all 0.
- Synchronizers: READY, TX_CLK_STABLE and RX_IDLE each pass through a 2-flop synchronizer, giving 2 cycles of latency; the results are called *_s.
- All outputs are registered and decoded from the next state, so outputs change on the same edge as state.
- Global priority: link_en=0 in any state → OFF on the next edge, retry count cleared.
- OFF (0):
  - Outputs: PWRDN=1, RESET_N=0.
  - link_en=1 → RST.
- RST (1):
  - Outputs: PWRDN=0, RESET_N=0.
  - Counter runs RESET_CYCLES cycles, then → WAIT_RDY.
- WAIT_RDY (2):
  - Outputs: PWRDN=0, RESET_N=1.
  - READY_s && STABLE_s → SETTLE.
  - Timer reaches READY_TIMEOUT → RETRY.
  - If both conditions hit on the same cycle, SETTLE wins.
- SETTLE (3):
  - Counter runs SETTLE_CYCLES cycles with READY_s && STABLE_s held, then → UP.
  - Any drop → RETRY.
- UP (4):
  - Outputs: TX_VAL=1, link_up=1.
  - Retry count cleared on entry.
  - READY_s or STABLE_s low → RETRY.
  - Idle counter increments while RX_IDLE_s=1 and clears when it is 0. Reaching IDLE_LOSS_CYCLES → RETRY.
  - The idle counter saturates and never wraps.
- RETRY (5):
  - One cycle with RESET_N=0, TX_VAL=0, link_up=0.
  - Retry count increments.
  - If the new count equals MAX_RETRIES → FAIL, else → RST.
- FAIL (6):
  - Outputs: PWRDN=1, RESET_N=0, link_fail=1.
  - Sticky until link_en=0.
- State 7 is unreachable; if reached, → OFF.
- TX_VAL and link_up drop on the same edge the FSM leaves UP.
- All counters reload to 0 on every state entry.
- Reset asserted mid-operation: all outputs return to reset values immediately, asynchronously.

Optional Feature:
Macro SERDES_EPCS3_LINK_STATS_EN.
- Defined: adds outputs link_loss_cnt [15:0] and timeout_cnt [15:0].
  - link_loss_cnt increments on each UP→RETRY.
  - timeout_cnt increments on each WAIT_RDY timeout.
  - Both saturate at 0xFFFF, clear only on reset, and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Bring-up (RESET_CYCLES=16, SETTLE_CYCLES=32): link_en=1, READY=STABLE=1 from cycle 0.
  - Required: RESET_N rises 16 cycles after RST entry.
  - Required: link_up=1 and TX_VAL=1 exactly 32 cycles after SETTLE entry; state=4.
- Timeout (READY_TIMEOUT=100, MAX_RETRIES=3): READY held 0.
  - Required: three RST/WAIT_RDY attempts, each lasting 100 cycles.
  - Required: then link_fail=1, PWRDN=1, state=6.
  - Required: link_en=0 → state=0 next edge; link_fail clears.
- Link loss (IDLE_LOSS_CYCLES=1024): in UP, assert RX_IDLE.
  - RX_IDLE for 1023 cycles then 0: link stays up.
  - RX_IDLE for 1024 consecutive cycles: TX_VAL=0 and state=5, then re-bring-up to UP.
- Ready drop: deassert READY in UP.
  - Required: link_up falls 3 edges later (2 sync + 1 registered).
  - Required: recovery to UP with retry count cleared on re-entry.
- Async reset mid-SETTLE: assert APB_S_PRESET_N=0 between edges.
  - Required: PWRDN=1 and RESET_N=0 immediately; state=0.
- SERDES_EPCS3_LINK_STATS_EN defined: force 2 link losses and 1 timeout.
  - Required: link_loss_cnt=2, timeout_cnt=1.
  - Required: a subsequent link_en toggle does not clear them.

Source files
------------

// File: rtl/serdes_epcs3_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serdes_epcs3_link_ctrl
// Brief   : Power-down/reset sequencing and link supervision for SERDES_IF
//           EPCS lane 3. Optional counters: SERDES_EPCS3_LINK_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module serdes_epcs3_link_ctrl #(
  parameter int RESET_CYCLES     = 16,
  parameter int READY_TIMEOUT    = 65535,
  parameter int SETTLE_CYCLES    = 32,
  parameter int IDLE_LOSS_CYCLES = 1024,
  parameter int MAX_RETRIES      = 3
) (
  input  logic        APB_S_PCLK,
  input  logic        APB_S_PRESET_N,
  input  logic        link_en,
  input  logic        EPCS_3_READY,
  input  logic        EPCS_3_TX_CLK_STABLE,
  input  logic        EPCS_3_RX_IDLE,
  output logic        EPCS_3_PWRDN,
  output logic        EPCS_3_RESET_N,
  output logic        EPCS_3_TX_VAL,
  output logic        link_up,
  output logic        link_fail,
`ifdef SERDES_EPCS3_LINK_STATS_EN
  output logic [15:0] link_loss_cnt,
  output logic [15:0] timeout_cnt,
`endif
  output logic [2:0]  state
);

  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] c_rst_last    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_tmo_last    = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_idle_last   = CNT_W'(IDLE_LOSS_CYCLES - 1);
  localparam logic [3:0]       c_max_retries = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_RST      = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_SETTLE   = 3'd3,
    S_UP       = 3'd4,
    S_RETRY    = 3'd5,
    S_FAIL     = 3'd6,
    S_BAD      = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [2:0]       sync1_q, sync2_q;
  logic             pwrdn_q, pwrdn_d;
  logic             rstn_q, rstn_d;
  logic             txval_q, txval_d;
  logic             up_q, up_d;
  logic             fail_q, fail_d;

  logic             w_ready_s, w_stable_s, w_idle_s, w_lane_ok;

  // Bit 0 READY, bit 1 TX_CLK_STABLE, bit 2 RX_IDLE.
  always_ff @(posedge APB_S_PCLK or negedge APB_S_PRESET_N) begin
    if (!APB_S_PRESET_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {EPCS_3_RX_IDLE, EPCS_3_TX_CLK_STABLE, EPCS_3_READY};
      sync2_q <= sync1_q;
    end
  end

  assign w_ready_s  = sync2_q[0];
  assign w_stable_s = sync2_q[1];
  assign w_idle_s   = sync2_q[2];
  assign w_lane_ok  = w_ready_s & w_stable_s;

  always_comb begin
    state_d = state_q;
    if (!link_en) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF:      state_d = S_RST;
        S_RST:      if (cnt_q == c_rst_last) state_d = S_WAIT_RDY;
        S_WAIT_RDY: begin
          // Lane coming ready beats a simultaneous timeout.
          if (w_lane_ok)                state_d = S_SETTLE;
          else if (cnt_q == c_tmo_last) state_d = S_RETRY;
        end
        S_SETTLE: begin
          if (!w_lane_ok)                  state_d = S_RETRY;
          else if (cnt_q == c_settle_last) state_d = S_UP;
        end
        S_UP: begin
          if (!w_lane_ok)                             state_d = S_RETRY;
          else if (w_idle_s && (cnt_q == c_idle_last)) state_d = S_RETRY;
        end
        S_RETRY: begin
          if ((retry_q + 4'd1) == c_max_retries) state_d = S_FAIL;
          else                                   state_d = S_RST;
        end
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_OFF;
      endcase
    end
  end

  // One shared timer; in UP it doubles as the saturating RX idle run length.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q) begin
      case (state_q)
        S_RST, S_WAIT_RDY, S_SETTLE: cnt_d = cnt_q + 16'd1;
        S_UP: begin
          if (w_idle_s) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_comb begin
    retry_d = retry_q;
    if (!link_en) begin
      retry_d = '0;
    end else if ((state_d == S_UP) && (state_q != S_UP)) begin
      retry_d = '0;
    end else if (state_q == S_RETRY) begin
      retry_d = retry_q + 4'd1;
    end
  end

  always_comb begin
    pwrdn_d = 1'b0;
    rstn_d  = 1'b0;
    txval_d = 1'b0;
    up_d    = 1'b0;
    fail_d  = 1'b0;
    case (state_d)
      S_OFF:                pwrdn_d = 1'b1;
      S_RST:                rstn_d  = 1'b0;
      S_WAIT_RDY, S_SETTLE: rstn_d  = 1'b1;
      S_UP: begin
        rstn_d  = 1'b1;
        txval_d = 1'b1;
        up_d    = 1'b1;
      end
      S_RETRY:              rstn_d  = 1'b0;
      S_FAIL: begin
        pwrdn_d = 1'b1;
        fail_d  = 1'b1;
      end
      default:              pwrdn_d = 1'b1;
    endcase
  end

  always_ff @(posedge APB_S_PCLK or negedge APB_S_PRESET_N) begin
    if (!APB_S_PRESET_N) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      retry_q <= '0;
      pwrdn_q <= 1'b1;
      rstn_q  <= 1'b0;
      txval_q <= 1'b0;
      up_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      pwrdn_q <= pwrdn_d;
      rstn_q  <= rstn_d;
      txval_q <= txval_d;
      up_q    <= up_d;
      fail_q  <= fail_d;
    end
  end

  assign EPCS_3_PWRDN   = pwrdn_q;
  assign EPCS_3_RESET_N = rstn_q;
  assign EPCS_3_TX_VAL  = txval_q;
  assign link_up        = up_q;
  assign link_fail      = fail_q;
  assign state          = state_q;

`ifdef SERDES_EPCS3_LINK_STATS_EN
  logic [15:0] loss_q, tmo_q;
  logic        w_loss_evt, w_tmo_evt;

  assign w_loss_evt = (state_q == S_UP) && (state_d == S_RETRY);
  assign w_tmo_evt  = (state_q == S_WAIT_RDY) && (state_d == S_RETRY);

  always_ff @(posedge APB_S_PCLK or negedge APB_S_PRESET_N) begin
    if (!APB_S_PRESET_N) begin
      loss_q <= '0;
      tmo_q  <= '0;
    end else begin
      if (w_loss_evt && (loss_q != 16'hFFFF)) loss_q <= loss_q + 16'd1;
      if (w_tmo_evt && (tmo_q != 16'hFFFF))   tmo_q  <= tmo_q + 16'd1;
    end
  end

  assign link_loss_cnt = loss_q;
  assign timeout_cnt   = tmo_q;
`else
  // Statistics counters not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_serdes_epcs3_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_serdes_epcs3_link_ctrl
// Brief   : Directed self-checking bench for serdes_epcs3_link_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serdes_epcs3_link_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       link_en;
  logic       rdy, stb, idle;
  logic       pwrdn, resetn, txval, link_up, link_fail;
  logic [2:0] state;
`ifdef SERDES_EPCS3_LINK_STATS_EN
  logic [15:0] link_loss_cnt, timeout_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  serdes_epcs3_link_ctrl #(
    .RESET_CYCLES     (16),
    .READY_TIMEOUT    (100),
    .SETTLE_CYCLES    (32),
    .IDLE_LOSS_CYCLES (1024),
    .MAX_RETRIES      (3)
  ) dut (
    .APB_S_PCLK           (clk),
    .APB_S_PRESET_N       (rst_n),
    .link_en              (link_en),
    .EPCS_3_READY         (rdy),
    .EPCS_3_TX_CLK_STABLE (stb),
    .EPCS_3_RX_IDLE       (idle),
    .EPCS_3_PWRDN         (pwrdn),
    .EPCS_3_RESET_N       (resetn),
    .EPCS_3_TX_VAL        (txval),
    .link_up              (link_up),
    .link_fail            (link_fail),
`ifdef SERDES_EPCS3_LINK_STATS_EN
    .link_loss_cnt        (link_loss_cnt),
    .timeout_cnt          (timeout_cnt),
`endif
    .state                (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Edges taken until state matches, bounded by budget.
  task automatic wait_state(input logic [2:0] st, input int budget, output int edges);
    edges = 0;
    while ((state !== st) && (edges < budget)) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  initial begin
    rst_n = 1'b0; link_en = 1'b0; rdy = 1'b0; stb = 1'b0; idle = 1'b0;
    step(3);
    chk("rst_pwrdn",  pwrdn,     1);
    chk("rst_resetn", resetn,    0);
    chk("rst_txval",  txval,     0);
    chk("rst_linkup", link_up,   0);
    chk("rst_fail",   link_fail, 0);
    chk("rst_state",  state,     0);

    // Bring-up with lane ready from the start
    rdy = 1'b1; stb = 1'b1; link_en = 1'b1;
    rst_n = 1'b1;
    step(1);
    chk("bu_rst_state",  state,  1);
    chk("bu_rst_pwrdn",  pwrdn,  0);
    chk("bu_rst_resetn", resetn, 0);
    wait_state(3'd2, 40, n);
    chk("bu_rst_len",    n,      16);
    chk("bu_wait_rstn",  resetn, 1);
    wait_state(3'd3, 10, n);
    chk("bu_wait_len",   n,      1);
    chk("bu_settle_up",  link_up, 0);
    wait_state(3'd4, 60, n);
    chk("bu_settle_len", n,      32);
    chk("bu_up_linkup",  link_up, 1);
    chk("bu_up_txval",   txval,  1);

    // RX idle one cycle short of the loss threshold
    idle = 1'b1;
    step(1023);
    idle = 1'b0;
    step(5);
    chk("idle1023_state",  state,   4);
    chk("idle1023_linkup", link_up, 1);

    // RX idle long enough to count as loss
    idle = 1'b1;
    wait_state(3'd5, 1100, n);
    chk("idle_loss_edges", n,       1026);
    chk("idle_loss_txval", txval,   0);
    chk("idle_loss_up",    link_up, 0);
    idle = 1'b0;
    step(1);
    chk("idle_retry_rst",  state,   1);
    wait_state(3'd4, 80, n);
    chk("idle_rebring",    n,       49);

    // Ready drops in UP; twice so a stale retry count would reach FAIL
    for (int k = 0; k < 2; k++) begin
      rdy = 1'b0;
      step(2);
      chk("rdrop_still_up", link_up, 1);
      step(1);
      chk("rdrop_linkup",   link_up, 0);
      chk("rdrop_state",    state,   5);
      rdy = 1'b1;
      step(1);
      chk("rdrop_next_rst", state,   1);
      wait_state(3'd4, 80, n);
      chk("rdrop_recover",  n,       49);
    end

    // Ready timeout until retries are exhausted
    link_en = 1'b0; rdy = 1'b0;
    step(1);
    chk("off_state", state, 0);
    chk("off_pwrdn", pwrdn, 1);
    link_en = 1'b1;
    step(1);
    chk("tmo_rst_entry", state, 1);
    for (int k = 0; k < 3; k++) begin
      wait_state(3'd2, 40, n);
      chk("tmo_rst_len",  n, 16);
      wait_state(3'd5, 200, n);
      chk("tmo_wait_len", n, 100);
      step(1);
      chk("tmo_after_retry", state, (k == 2) ? 6 : 1);
    end
    chk("fail_flag",   link_fail, 1);
    chk("fail_pwrdn",  pwrdn,     1);
    chk("fail_resetn", resetn,    0);
    step(20);
    chk("fail_sticky", state,     6);
    link_en = 1'b0;
    step(1);
    chk("fail_off_state", state,     0);
    chk("fail_off_flag",  link_fail, 0);

    // Async reset while in SETTLE
    rdy = 1'b1; link_en = 1'b1;
    wait_state(3'd3, 60, n);
    chk("ar_settle_edges", n, 18);
    step(5);
    chk("ar_pre_resetn", resetn, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pwrdn",  pwrdn,   1);
    chk("ar_resetn", resetn,  0);
    chk("ar_state",  state,   0);
    chk("ar_linkup", link_up, 0);

`ifdef SERDES_EPCS3_LINK_STATS_EN
    step(2);
    chk("st_rst_loss", link_loss_cnt, 0);
    chk("st_rst_tmo",  timeout_cnt,   0);
    rst_n = 1'b1;
    wait_state(3'd4, 80, n);
    idle = 1'b1;
    wait_state(3'd5, 1100, n);
    idle = 1'b0;
    wait_state(3'd4, 80, n);
    rdy = 1'b0;
    wait_state(3'd5, 10, n);
    step(1);
    wait_state(3'd5, 200, n);
    chk("st_loss", link_loss_cnt, 2);
    chk("st_tmo",  timeout_cnt,   1);
    link_en = 1'b0;
    step(2);
    link_en = 1'b1;
    step(5);
    chk("st_loss_keep", link_loss_cnt, 2);
    chk("st_tmo_keep",  timeout_cnt,   1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
